// File: rtl/vga_stream_gen.sv
// -----------------------------------------------------------------------------
// vga_stream_gen
//
// Front end of the Pong pipeline. Walks the raster with a horizontal pixel
// counter (hc) and a vertical line counter (vc), decodes sync/blanking from
// the current position and registers the result into the 23-bit VGA stream
// consumed by the court, scoreboard, player, ball and endframe stages.
//
// Ports
//   px_clk     in   1   pixel clock, sole clock domain
//   reset      in   1   synchronous, active-high reset
//   strVGA     out  23  {activevideo, x[9:0], y[9:0], hsync, vsync}
//   endframe   out  1   one-cycle strobe on the last pixel of each frame
//   frame_cnt  out  8   frames completed, steps together with endframe
//
// strVGA is valid every cycle; there is no handshake. Output latency is one
// cycle from counter value to stream. x/y are the raw counter values and are
// not masked during blanking.
//
// H_TOT and V_TOT must each fit a 10-bit counter (<= 1024).
// -----------------------------------------------------------------------------
module vga_stream_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        px_clk,
   input  logic        reset,
   output logic [22:0] strVGA,
   output logic        endframe,
   output logic [7:0]  frame_cnt
);

   localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // All compare points held at the full 10-bit counter width. Sync windows
   // use inclusive last-pixel bounds so a window ending at 1023 cannot wrap.
   localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
   localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

   // Idle stream: blanked, origin, both sync lines at their inactive level.
   localparam logic [22:0] STR_RESET = {1'b0, 10'd0, 10'd0, ~SYNC_POL, ~SYNC_POL};

   logic [9:0] hc;
   logic [9:0] vc;
   logic       h_wrap;
   logic       v_last;
   logic       frame_end;
   logic       active;
   logic       hs_raw;
   logic       vs_raw;
   logic       hsync;
   logic       vsync;

   // ---------------------------------------------------------------- counters
   assign h_wrap    = (hc == H_LAST);
   assign v_last    = (vc == V_LAST);
   assign frame_end = h_wrap && v_last;

   always_ff @(posedge px_clk) begin
      if (reset) begin
         hc <= 10'd0;
         vc <= 10'd0;
      end else begin
         if (h_wrap) begin
            hc <= 10'd0;
            if (v_last) begin
               vc <= 10'd0;
            end else begin
               vc <= vc + 10'd1;
            end
         end else begin
            hc <= hc + 10'd1;
         end
      end
   end

   // ------------------------------------------------------------------ decode
   assign active = (hc < H_ACT_END) && (vc < V_ACT_END);
   assign hs_raw = (hc >= H_SYNC_FIRST) && (hc <= H_SYNC_LAST);
   assign vs_raw = (vc >= V_SYNC_FIRST) && (vc <= V_SYNC_LAST);

   // XOR with the inverted polarity: pass-through when SYNC_POL=1,
   // inversion (active-low pulses) when SYNC_POL=0.
   assign hsync = hs_raw ^ ~SYNC_POL;
   assign vsync = vs_raw ^ ~SYNC_POL;

   // --------------------------------------------------------- output register
   // frame_cnt steps on the same edge that raises endframe so downstream logic
   // sees the new frame number alongside the strobe.
   always_ff @(posedge px_clk) begin
      if (reset) begin
         strVGA    <= STR_RESET;
         endframe  <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         strVGA   <= {active, hc, vc, hsync, vsync};
         endframe <= frame_end;
         if (frame_end) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/vga_stream_gen.md
Name: vga_stream_gen

Overview:
- Upstream stage of the Pong game block. Generates the 23-bit VGA timing stream `strVGA` from the pixel clock.
- Consumers of `strVGA`: the court, scoreboard, players, ball and endframe logic.
- Counts horizontal and vertical pixel positions and derives the hsync, vsync and activevideo flags.
- Also provides a one-cycle end-of-frame strobe and a free-running frame counter for dynamic logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low sync pulses)

Ports:
- px_clk  input  1  pixel clock; the only clock
- reset  input  1  synchronous, active-high reset
- strVGA  output  23  VGA stream: [22]=activevideo, [21:12]=x, [11:2]=y, [1]=hsync, [0]=vsync
- endframe  output  1  one-cycle pulse at the last pixel of each frame
- frame_cnt  output  8  frame counter, incremented at each endframe, wraps 255->0

Behaviour:
- Clocking and reset
  - One clock: `px_clk`. Reset is synchronous and active-high on `reset`.
  - All state updates on the rising edge of `px_clk`.
- Counters
  - hc: 10 bits, range 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800).
  - vc: 10 bits, range 0..V_TOT-1, where V_TOT = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (default 525).
  - hc increments every cycle and wraps H_TOT-1 -> 0.
  - vc increments only when hc wraps, and wraps V_TOT-1 -> 0 when hc and vc are both at their maximum.
- Decode, computed from the current (hc, vc)
  - active = (hc < H_ACTIVE) && (vc < V_ACTIVE)
  - hs_raw = hc in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]
  - vs_raw = vc in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]
  - hsync = SYNC_POL ? hs_raw : ~hs_raw; vsync likewise from vs_raw.
- Output register (single stage)
  - `strVGA` and `endframe` are registered. Latency is exactly 1 cycle from counter value to output.
  - The output carries x=hc and y=vc, including during blanking; x and y are not masked outside the active area.
  - endframe register = 1 when (hc==H_TOT-1 && vc==V_TOT-1), else 0. High for exactly one cycle per frame.
  - frame_cnt increments in the same cycle the endframe register is set, so the new value and the endframe pulse appear together.
- Reset, at any time including mid-frame
  - hc=0, vc=0, frame_cnt=0, endframe=0.
  - strVGA = {0, 10'd0, 10'd0, ~SYNC_POL, ~SYNC_POL}, i.e. sync lines inactive and activevideo low.
  - First cycle after reset deasserts: counters at (0,0). Next edge: output shows activevideo=1, x=0, y=0.
- Reset held for several cycles: outputs stay at their reset values and counters do not advance.
- Boundary cases
  - No output glitches at wrap: at hc=H_TOT-1, vc=V_TOT-1 the next cycle is (0,0) with activevideo=1.
  - frame_cnt wraps 255 -> 0 silently.
- Width rule: H_TOT and V_TOT must each be ≤ 1024. Counter compares use a full 10-bit unsigned width.
- No handshake: `strVGA` is valid every cycle, and downstream stages sample it unconditionally.

Test Plan:
- Release reset, then run 800 cycles -> output x sequence 0..799 then 0; y=0 throughout; y becomes 1 on the cycle output x returns to 0.
- Full frame (420000 cycles) -> exactly one endframe pulse, one cycle wide, coinciding with output x=799, y=524; frame_cnt=1 in the same cycle.
- Line 0 -> hsync low exactly for output x=656..751 (96 cycles); activevideo high for x=0..639 and low for x=640..799.
- Frame -> vsync low exactly on lines y=490..491 (1600 cycles); activevideo low for all of y=480..524.
- Assert reset for 3 cycles at x=300, y=200 -> output equals the reset pattern (strVGA=23'h000003) during reset; one cycle after release output x=0, y=0, activevideo=1; frame_cnt=0.
- Run 256 frames -> frame_cnt goes 255 -> 0 on the 256th endframe; endframe count = 256.
